// File: rtl/encoder_pkg.sv
// encoder_pkg
//   Shared types and constants for the 4-to-2 sequential encoder slice.
//   Holds the two-state machine enum, the 2-bit index type, the reset
//   value of the round-robin pointer and a capture-request helper.
//   Optional feature macro used by the slice: ENCODER_RR_EN.
package encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [1:0] idx_t;

  // After reset the pointer sits on 3 so the first search starts at D0.
  localparam idx_t RR_PTR_RST = 2'b11;

  // A capture needs both the enable and at least one request bit.
  function automatic logic is_capture(input logic en, input logic [3:0] d);
    return en && (d != 4'b0000);
  endfunction

endpackage

// File: rtl/encoder_4_to_2_seq_if.sv
// encoder_4_to_2_seq_if
//   Bundles the request side (EN, D), the downstream handshake (V, RDY)
//   and the status outputs (A, ERR, DROP_CNT) of encoder_4_to_2_seq.
//   Modports:
//     master : drives EN, D, RDY; observes A, V, ERR, DROP_CNT
//     slave  : the encoder itself
//   Parameter DROP_W sets the width of DROP_CNT and must match the
//   encoder's DROP_W.
interface encoder_4_to_2_seq_if
  import encoder_pkg::*;
#(
  parameter int DROP_W = 8
);

  logic              EN;
  logic [3:0]        D;
  logic              RDY;
  idx_t              A;
  logic              V;
  logic              ERR;
  logic [DROP_W-1:0] DROP_CNT;

  modport master (
    output EN, D, RDY,
    input  A, V, ERR, DROP_CNT
  );

  modport slave (
    input  EN, D, RDY,
    output A, V, ERR, DROP_CNT
  );

endinterface

// File: rtl/prio_pick4.sv
// prio_pick4
//   Combinational priority search over a 4-bit request vector.
//   Ports:
//     vec   in  4  request vector
//     start in  2  first index examined (round-robin build only)
//     idx   out 2  index of the selected request
//     multi out 1  two or more bits of vec are set
//   ENCODER_RR_EN defined   : search starts at 'start' and walks upward
//                             with wrap; first set bit wins.
//   ENCODER_RR_EN undefined : fixed priority, highest set bit wins and
//                             'start' is not used.
module prio_pick4
  import encoder_pkg::*;
(
  input  logic [3:0] vec,
  input  idx_t       start,
  output idx_t       idx,
  output logic       multi
);

`ifdef ENCODER_RR_EN
  logic [7:0] dbl;
  logic [3:0] rot;
  idx_t       off;

  // Rotate the vector so 'start' lands on bit 0, take the lowest set
  // bit of the rotated copy and rotate the answer back.
  always_comb begin
    dbl = {vec, vec};
    rot = dbl[start +: 4];
    off = '0;
    for (int i = 3; i >= 0; i--) begin
      if (rot[i]) off = 2'(i);
    end
    idx = start + off;
  end
`else
  logic unused_start;
  assign unused_start = ^start;

  // Later (higher) set bits overwrite earlier ones, so D3 wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (vec[i]) idx = 2'(i);
    end
  end
`endif

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = (vec & (vec - 4'd1)) != 4'd0;

endmodule

// File: rtl/encoder_4_to_2_seq.sv
// encoder_4_to_2_seq
//   Registered 4-to-2 encoder with a valid/ready output beat.
//   A capture request (EN=1, D!=0) loads A/ERR and raises V; the beat is
//   held until RDY. Captures refused while stalled bump a saturating
//   drop counter.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of encoder_4_to_2_seq_if
//              EN, D, RDY in; A, V, ERR, DROP_CNT out
//   Parameter DROP_W: width of DROP_CNT (default 8).
//   Macro ENCODER_RR_EN: round-robin priority instead of fixed D3..D0.
module encoder_4_to_2_seq
  import encoder_pkg::*;
#(
  parameter int DROP_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  encoder_4_to_2_seq_if.slave bus
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_t state;
  logic   cap_req;
  idx_t   pick_start;
  idx_t   pick_idx;
  logic   pick_multi;

  assign cap_req = is_capture(bus.EN, bus.D);

`ifdef ENCODER_RR_EN
  idx_t rr_ptr;

  // On a transfer edge the pointer is about to become the outgoing A, so
  // a beat loaded on that same edge must already search from A+1.
  assign pick_start = ((state == HOLD && bus.RDY) ? bus.A : rr_ptr) + 2'd1;
`else
  assign pick_start = '0;
`endif

  prio_pick4 u_pick (
    .vec   (bus.D),
    .start (pick_start),
    .idx   (pick_idx),
    .multi (pick_multi)
  );

  // IDLE/HOLD machine; V, A, ERR and DROP_CNT are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bus.V        <= 1'b0;
      bus.A        <= 2'b00;
      bus.ERR      <= 1'b0;
      bus.DROP_CNT <= '0;
`ifdef ENCODER_RR_EN
      rr_ptr       <= RR_PTR_RST;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cap_req) begin
            bus.A   <= pick_idx;
            bus.ERR <= pick_multi;
            bus.V   <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (bus.RDY) begin
`ifdef ENCODER_RR_EN
            rr_ptr <= bus.A;
`endif
            if (cap_req) begin
              bus.A   <= pick_idx;
              bus.ERR <= pick_multi;
            end else begin
              bus.V <= 1'b0;
              state <= IDLE;
            end
          end else if (cap_req && bus.DROP_CNT != DROP_MAX) begin
            bus.DROP_CNT <= bus.DROP_CNT + DROP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          bus.V <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encoder_4_to_2_seq.sv
// tb_encoder_4_to_2_seq
//   Scoreboard bench for encoder_4_to_2_seq. A reference model pushes the
//   expected beat whenever a capture is accepted; a monitor on the falling
//   edge pops/compares beats as they are presented and checks V and
//   DROP_CNT every cycle. Honours ENCODER_RR_EN like the design.
module tb_encoder_4_to_2_seq;
  import encoder_pkg::*;

  localparam int DROP_W = 8;

  typedef struct packed {
    logic [1:0] a;
    logic       err;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  encoder_4_to_2_seq_if #(.DROP_W(DROP_W)) bus ();

  encoder_4_to_2_seq #(.DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  beat_t             sb_q[$];
  logic              m_hold;
  logic [DROP_W-1:0] m_drop;
  logic [1:0]        m_cur_a;
`ifdef ENCODER_RR_EN
  logic [1:0]        m_ptr;
`endif

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level selection rule: fixed = highest set bit; round-robin =
  // first set bit found walking up from pointer+1 with wrap.
  function automatic logic [1:0] ref_pick(input logic [3:0] d);
`ifdef ENCODER_RR_EN
    for (int step = 1; step <= 4; step++) begin
      int k = (int'(m_ptr) + step) % 4;
      if (d[k]) return 2'(k);
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (d[k]) return 2'(k);
    end
`endif
    return 2'b00;
  endfunction

  task automatic model_load(input logic [3:0] d);
    beat_t b;
    m_cur_a = ref_pick(d);
    b.a     = m_cur_a;
    b.err   = ($countones(d) >= 2);
    sb_q.push_back(b);
    m_hold  = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold  = 1'b0;
      m_drop  = '0;
      m_cur_a = 2'b00;
      sb_q.delete();
`ifdef ENCODER_RR_EN
      m_ptr   = 2'b11;
`endif
    end else begin
      logic cap;
      cap = bus.EN && (bus.D != 4'b0000);
      if (!m_hold) begin
        if (cap) model_load(bus.D);
      end else if (bus.RDY) begin
`ifdef ENCODER_RR_EN
        m_ptr = m_cur_a;
`endif
        if (cap) model_load(bus.D);
        else     m_hold = 1'b0;
      end else if (cap && m_drop != {DROP_W{1'b1}}) begin
        m_drop = m_drop + 1'b1;
      end
    end
  end

  // Monitor: mid-cycle, compare presented outputs against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      check_output("reset_v",    32'(bus.V),        32'd0);
      check_output("reset_a",    32'(bus.A),        32'd0);
      check_output("reset_err",  32'(bus.ERR),      32'd0);
      check_output("reset_drop", 32'(bus.DROP_CNT), 32'd0);
    end else begin
      check_output("valid",    32'(bus.V),        32'(m_hold));
      check_output("drop_cnt", 32'(bus.DROP_CNT), 32'(m_drop));
      if (bus.V) begin
        if (sb_q.size() == 0) begin
          check_output("beat_expected", 32'd0, 32'd1);
        end else begin
          beat_t exp_b;
          if (bus.RDY) exp_b = sb_q.pop_front();
          else         exp_b = sb_q[0];
          check_output("beat_a",   32'(bus.A),   32'(exp_b.a));
          check_output("beat_err", 32'(bus.ERR), 32'(exp_b.err));
        end
      end
    end
  end

  task automatic apply_stimulus(input logic en, input logic [3:0] d, input logic rdy);
    @(posedge clk);
    #2;
    bus.EN  = en;
    bus.D   = d;
    bus.RDY = rdy;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.EN   = 1'b0;
    bus.D    = 4'b0000;
    bus.RDY  = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single beat with one-cycle latency, then drains.
    apply_stimulus(1'b1, 4'b0100, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("first_beat_v",   32'(bus.V),   32'd1);
    check_output("first_beat_a",   32'(bus.A),   32'd2);
    check_output("first_beat_err", 32'(bus.ERR), 32'd0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("first_beat_drain", 32'(bus.V), 32'd0);

    // Multi-hot vector: A=3 in both priority modes here, ERR set.
    apply_stimulus(1'b1, 4'b1011, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("multi_a",   32'(bus.A),   32'd3);
    check_output("multi_err", 32'(bus.ERR), 32'd1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);

    // Stall: three refused captures while RDY=0.
    apply_stimulus(1'b1, 4'b0001, 1'b1);
    repeat (3) apply_stimulus(1'b1, 4'b0010, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("stall_drop", 32'(bus.DROP_CNT), 32'd3);
    check_output("stall_a",    32'(bus.A),        32'd0);
    check_output("stall_v",    32'(bus.V),        32'd1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);

    // Back-to-back beats, alternating vectors.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1'b1, (i % 2 == 0) ? 4'b0001 : 4'b1000, 1'b1);
    end
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);

    // All requests held (round-robin rotation when enabled).
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 4'b1111, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 4'($urandom),
                     $urandom_range(0, 2) != 0);
    end
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);

    // Saturate the drop counter.
    apply_stimulus(1'b1, 4'b0100, 1'b1);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'b1, 4'($urandom_range(1, 15)), 1'b0);
    end
    check_output("drop_saturated", 32'(bus.DROP_CNT), 32'(8'hFF));
    check_output("drop_sat_v",     32'(bus.V),        32'd1);

    // Asynchronous reset while a beat is pending.
    #1 rst_n = 1'b0;
    #1;
    check_output("async_rst_v",    32'(bus.V),        32'd0);
    check_output("async_rst_drop", 32'(bus.DROP_CNT), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First edge after reset behaves as IDLE.
    apply_stimulus(1'b1, 4'b0010, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("post_rst_a", 32'(bus.A), 32'd1);
    for (int i = 0; i < 100; i++) begin
      apply_stimulus($urandom_range(0, 1) != 0, 4'($urandom),
                     $urandom_range(0, 1) != 0);
    end
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_4_to_2_seq.md
ENCODER_4_TO_2_SEQ -- requirements
Module: encoder_4_to_2_seq

Interface
REQ-001 Parameter: DROP_W, default 8, width of the saturating drop counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 EN  input  1  capture enable; D is ignored while 0.
REQ-005 D  input  4  request lines, D[k] = request k.
REQ-006 A  output  2  encoded index of the granted request.
REQ-007 V  output  1  output beat valid.
REQ-008 RDY  input  1  downstream ready; a beat transfers when V=1 and RDY=1.
REQ-009 ERR  output  1  more than one D bit was set in the captured vector; qualified by V.
REQ-010 DROP_CNT  output  DROP_W  count of capture requests refused due to stall.

Function
REQ-011 The block is a two-state machine: IDLE (V=0) and HOLD (V=1).
REQ-012 A capture request is EN=1 and D!=0 on a clock edge.
REQ-013 In IDLE, a capture request shall load A, ERR and V=1 on that edge and enter HOLD; latency is one cycle from D to V.
REQ-014 In HOLD with RDY=0, A, V and ERR shall hold unchanged and D shall be ignored.
REQ-015 In HOLD with RDY=1 and a capture request on the same edge, the new beat shall load and the state shall stay HOLD, giving one beat per cycle.
REQ-016 In HOLD with RDY=1 and no capture request, the state shall go to IDLE with V=0.
REQ-017 EN=1 with D=0 shall never produce a beat.
REQ-018 Fixed priority: D3 highest down to D0, and A = index of the highest set bit.
REQ-019 ERR shall be 1 when the captured D has two or more bits set, else 0.
REQ-020 A capture request on an edge where HOLD and RDY=0 shall increment DROP_CNT by 1, saturating at all-ones with no wrap.
REQ-021 RDY is ignored while V=0; A and ERR are don't-care while V=0 but shall not change except on a load.

Reset
REQ-022 While rst_n=0: state IDLE, V=0, A=2'b00, ERR=0, DROP_CNT=0, and the round-robin pointer is 2'b11.
REQ-023 Reset mid-HOLD shall discard the pending beat immediately, without waiting for a clock.
REQ-024 The first edge after rst_n rises shall behave as IDLE.

Configuration
REQ-025 Macro ENCODER_RR_EN: when defined, priority shall be round-robin; when undefined, REQ-018 fixed priority applies and no pointer register exists.
REQ-026 With ENCODER_RR_EN, the search starts at (pointer+1) mod 4 and proceeds upward with wrap, and A is the first set bit found.
REQ-027 With ENCODER_RR_EN, the pointer shall update to A only when a beat transfers (V=1 and RDY=1), not on load.
REQ-028 ERR and DROP_CNT behaviour shall be identical with and without ENCODER_RR_EN.

Structure
REQ-029 A shared package encoder_pkg shall hold the state enum (IDLE, HOLD), the index type (2-bit), and the constant RR_PTR_RST = 2'b11.
REQ-030 The priority search is a natural sub-module, prio_pick4 (inputs: vector and start index; outputs: index and multi-hot flag), instantiated once.

Verification
REQ-031 Reset, then EN=1, D=4'b0100, RDY=1 -> next cycle V=1, A=2'b10, ERR=0; one cycle later V=0.
REQ-032 Fixed priority, D=4'b1011 -> A=2'b11, ERR=1.
REQ-033 Stall: load D=4'b0001, RDY=0 for 3 cycles with EN=1, D=4'b0010 -> A stays 2'b00, V=1, DROP_CNT=3; then RDY=1 -> beat transfers.
REQ-034 Back-to-back: RDY=1, D alternating 4'b0001/4'b1000 each cycle -> V stays 1 and A alternates 00/11 with one-cycle latency.
REQ-035 With ENCODER_RR_EN, D=4'b1111 held and RDY=1 -> A sequence 00, 01, 10, 11, 00, each beat with ERR=1.
REQ-036 Drive rst_n=0 asynchronously while V=1 -> V=0 and DROP_CNT=0 before the next clk edge; force DROP_CNT to all-ones via stalls -> it holds at all-ones.
